// File: rtl/lua_proc_pkg.sv
// -----------------------------------------------------------------------------
// lua_proc_pkg
// Shared constants and types for the instruction-fetch front end.
//   INST_W        instruction word width
//   OPCODE_W      opcode field width (inst[OPCODE_W-1:0])
//   fetch_state_t fetch sequencer state encoding
// -----------------------------------------------------------------------------
package lua_proc_pkg;

  localparam int INST_W   = 32;
  localparam int OPCODE_W = 6;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Bundles the instruction-memory read port, the redirect input and the
// decode-side handshake of the fetch unit.
//   master : the fetch unit (drives mem_req/mem_addr and the inst_* head)
//   slave  : memory + decode + branch unit (drive ack/rdata/redirect/ready)
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
  parameter int ADDR_W = 16
);

  logic                            mem_req;
  logic [ADDR_W-1:0]               mem_addr;
  logic                            mem_ack;
  logic [lua_proc_pkg::INST_W-1:0] mem_rdata;
  logic                            redirect_valid;
  logic [ADDR_W-1:0]               redirect_pc;
  logic                            inst_valid;
  logic [lua_proc_pkg::INST_W-1:0] inst;
  logic [ADDR_W-1:0]               inst_pc;
  logic                            inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Prefetch queue of {instruction, pc} entries.
//   clk_id, n_reset  clock / async active-low reset (storage cleared to 0)
//   push, push_data  write an entry (ignored when full or flushing)
//   pop              drop the head (ignored when empty or flushing)
//   flush            empty the queue; wins over push and pop
//   full, empty      occupancy flags
//   head             current head entry
//   count            number of valid entries
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                     clk_id,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  // One extra pointer bit separates full from empty.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign head    = store[rd_ptr[PTR_W-1:0]];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk_id or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr[PTR_W-1:0]] <= push_data;
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction prefetcher: issues one word read at a time, queues returned
// words with their pc, and presents the queue head to decode. A redirect
// flushes the queue and restarts fetching at the new pc; a read that was in
// flight at the redirect is drained and its data thrown away.
//   clk_id           clock
//   n_reset          async active-low reset
//   bus (master)     memory port, redirect input, decode handshake
//   stall_count      [INST_FETCH_STATS_EN only] cycles decode was starved,
//                    saturating at 16'hFFFF
// Build option: `define INST_FETCH_STATS_EN adds the stall_count output.
//
// state | meaning
// IDLE  | no read outstanding; waiting for queue space
// REQ   | read of pc outstanding; acked data is queued
// DRAIN | read of a pre-redirect address outstanding; data will be dropped
// -----------------------------------------------------------------------------
module inst_fetch
  import lua_proc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk_id,
  input  logic         n_reset,
  inst_fetch_if.master bus
`ifdef INST_FETCH_STATS_EN
  ,
  output logic [15:0]  stall_count
`endif
);

  localparam logic [1:0] ST_IDLE  = FETCH_IDLE;
  localparam logic [1:0] ST_REQ   = FETCH_REQ;
  localparam logic [1:0] ST_DRAIN = FETCH_DRAIN;
  localparam int         CNT_W    = $clog2(DEPTH) + 1;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        pc_nxt;
  logic [ADDR_W-1:0]        drain_addr;

  logic                     q_push;
  logic                     q_pop;
  logic                     q_full;
  logic                     q_empty;
  logic [INST_W+ADDR_W-1:0] q_head;
  logic [CNT_W-1:0]         q_count;
  logic [CNT_W-1:0]         fill_nxt;
  logic                     take_redirect_in_req;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_fifo (
    .clk_id    (clk_id),
    .n_reset   (n_reset),
    .push      (q_push),
    .push_data ({bus.mem_rdata, pc}),
    .pop       (q_pop),
    .flush     (bus.redirect_valid),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head),
    .count     (q_count)
  );

  // Credit rule keeps the queue from overflowing; ~q_full is a backstop only.
  assign q_push = (state == ST_REQ) & bus.mem_ack & ~bus.redirect_valid & ~q_full;
  assign q_pop  = ~q_empty & bus.inst_ready;

  // Occupancy after this edge's push/pop, used for the stay-in-REQ decision.
  assign fill_nxt = q_count + CNT_W'(q_push) - CNT_W'(q_pop);

  assign take_redirect_in_req = (state == ST_REQ) & bus.redirect_valid & ~bus.mem_ack;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_IDLE: begin
        if (bus.redirect_valid)
          pc_nxt = bus.redirect_pc;
        else if (q_count < CNT_W'(DEPTH))
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          state_nxt = bus.mem_ack ? ST_REQ : ST_DRAIN;
        end else if (bus.mem_ack) begin
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = (fill_nxt < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect_valid) pc_nxt = bus.redirect_pc;
        if (bus.mem_ack) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_id or negedge n_reset) begin
    if (!n_reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // Remember the abandoned address so mem_addr stays stable while draining.
      if (take_redirect_in_req) drain_addr <= pc;
    end
  end

  assign bus.mem_req    = (state == ST_REQ) | (state == ST_DRAIN);
  assign bus.mem_addr   = (state == ST_DRAIN) ? drain_addr : pc;
  assign bus.inst_valid = ~q_empty;
  assign bus.inst       = q_head[INST_W+ADDR_W-1:ADDR_W];
  assign bus.inst_pc    = q_head[ADDR_W-1:0];

`ifdef INST_FETCH_STATS_EN
  always_ff @(posedge clk_id or negedge n_reset) begin
    if (!n_reset)
      stall_count <= '0;
    else if (bus.inst_ready && q_empty && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic clk_id = 1'b0;
  logic n_reset;

  always #5 clk_id = ~clk_id;

  inst_fetch_if #(.ADDR_W(16)) bus ();

`ifdef INST_FETCH_STATS_EN
  logic [15:0] stall_count;
`endif

  inst_fetch #(
    .ADDR_W   (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk_id  (clk_id),
    .n_reset (n_reset),
    .bus     (bus)
`ifdef INST_FETCH_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          ack_cnt = 0;
  logic [15:0] last_ack_addr = 16'h0;

  function automatic logic [31:0] rdata_of(input logic [15:0] a);
    return 32'hC0DE_0000 | {16'h0000, a};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and play the memory for that cycle.
  task automatic next_cyc(input bit auto_ack);
    @(negedge clk_id);
    bus.mem_ack   = auto_ack & bus.mem_req;
    bus.mem_rdata = rdata_of(bus.mem_addr);
    if (bus.mem_ack) begin
      ack_cnt++;
      last_ack_addr = bus.mem_addr;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_id);
    n_reset            = 1'b0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    #1;
    check_val("rst_mem_req",    64'(bus.mem_req),    64'h0);
    check_val("rst_mem_addr",   64'(bus.mem_addr),   64'h0);
    check_val("rst_inst_valid", 64'(bus.inst_valid), 64'h0);
    check_val("rst_inst",       64'(bus.inst),       64'h0);
    check_val("rst_inst_pc",    64'(bus.inst_pc),    64'h0);
`ifdef INST_FETCH_STATS_EN
    check_val("rst_stall_count", 64'(stall_count), 64'h0);
`endif
    repeat (2) @(negedge clk_id);
    n_reset = 1'b1;
  endtask

  initial begin
    n_reset = 1'b0;

    // Streaming with zero-wait memory and an always-ready decoder.
    do_reset();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cyc(1'b1);
      check_val("stream_mem_req",  64'(bus.mem_req),  64'h1);
      check_val("stream_mem_addr", 64'(bus.mem_addr), 64'(i));
      check_val("stream_valid",    64'(bus.inst_valid), (i > 0) ? 64'h1 : 64'h0);
      if (i > 0) begin
        check_val("stream_inst_pc", 64'(bus.inst_pc), 64'(i - 1));
        check_val("stream_inst",    64'(bus.inst),    64'(rdata_of(16'(i - 1))));
      end
    end

    // Decoder stalled: queue fills with exactly DEPTH words, then one pop frees one slot.
    do_reset();
    ack_cnt = 0;
    repeat (12) next_cyc(1'b1);
    check_val("full_ack_cnt", 64'(ack_cnt),        64'd4);
    check_val("full_mem_req", 64'(bus.mem_req),    64'h0);
    check_val("full_valid",   64'(bus.inst_valid), 64'h1);
    check_val("full_head_pc", 64'(bus.inst_pc),    64'h0);
    bus.inst_ready = 1'b1;
    next_cyc(1'b1);
    bus.inst_ready = 1'b0;
    check_val("pop_head_pc", 64'(bus.inst_pc), 64'h1);
    ack_cnt = 0;
    repeat (8) next_cyc(1'b1);
    check_val("refill_ack_cnt",  64'(ack_cnt),       64'd1);
    check_val("refill_ack_addr", 64'(last_ack_addr), 64'h4);
    check_val("refill_mem_req",  64'(bus.mem_req),   64'h0);
    check_val("refill_head_pc",  64'(bus.inst_pc),   64'h1);

    // Slow memory with a redirect during the wait: old address held, data dropped.
    do_reset();
    bus.inst_ready = 1'b1;
    next_cyc(1'b0);
    check_val("slow_req",  64'(bus.mem_req),  64'h1);
    check_val("slow_addr", 64'(bus.mem_addr), 64'h0);
    next_cyc(1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0100;
    next_cyc(1'b0);
    bus.redirect_valid = 1'b0;
    check_val("drain_req",  64'(bus.mem_req),  64'h1);
    check_val("drain_addr", 64'(bus.mem_addr), 64'h0);
    next_cyc(1'b1);
    check_val("drain_ack_addr", 64'(bus.mem_addr), 64'h0);
    next_cyc(1'b1);
    check_val("after_drain_addr",  64'(bus.mem_addr),   64'h0100);
    check_val("after_drain_valid", 64'(bus.inst_valid), 64'h0);
    next_cyc(1'b1);
    check_val("redir_valid",   64'(bus.inst_valid), 64'h1);
    check_val("redir_inst_pc", 64'(bus.inst_pc),    64'h0100);
    check_val("redir_inst",    64'(bus.inst),       64'(rdata_of(16'h0100)));

    // Redirect on an ack edge with two entries queued.
    do_reset();
    next_cyc(1'b1);
    next_cyc(1'b1);
    next_cyc(1'b1);
    check_val("pre_redir_valid", 64'(bus.inst_valid), 64'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0200;
    next_cyc(1'b1);
    bus.redirect_valid = 1'b0;
    check_val("ack_redir_valid", 64'(bus.inst_valid), 64'h0);
    check_val("ack_redir_addr",  64'(bus.mem_addr),   64'h0200);
    check_val("ack_redir_req",   64'(bus.mem_req),    64'h1);
    bus.inst_ready = 1'b1;
    next_cyc(1'b1);
    check_val("ack_redir_new_valid", 64'(bus.inst_valid), 64'h1);
    check_val("ack_redir_new_pc",    64'(bus.inst_pc),    64'h0200);

    // PC wrap at the top of the address space, via redirect while idle.
    do_reset();
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFF;
    next_cyc(1'b1);
    bus.redirect_valid = 1'b0;
    check_val("idle_redir_req", 64'(bus.mem_req), 64'h0);
    next_cyc(1'b1);
    check_val("wrap_addr_top", 64'(bus.mem_addr), 64'hFFFF);
    next_cyc(1'b1);
    check_val("wrap_addr_zero", 64'(bus.mem_addr), 64'h0000);
    check_val("wrap_inst_pc",   64'(bus.inst_pc),  64'hFFFF);

`ifdef INST_FETCH_STATS_EN
    // Starve decode by never acking the memory.
    do_reset();
    bus.inst_ready = 1'b1;
    repeat (5) next_cyc(1'b0);
    check_val("stall_5", 64'(stall_count), 64'd5);
    repeat (70000) next_cyc(1'b0);
    check_val("stall_sat", 64'(stall_count), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
